// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared types, constants and helpers for the frog mover
// Contents:
//   LANES_DEF     default track width
//   MAX_LANES     widest track onehot_start can describe
//   frog_state_t  PLAY / LOCK / GOAL
//   onehot_start  start-of-track position (bit0 set) for an n-lane track
package frog_pkg;

  localparam int LANES_DEF = 19;
  localparam int MAX_LANES = 64;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    LOCK = 2'd1,
    GOAL = 2'd2
  } frog_state_t;

  function automatic logic [MAX_LANES-1:0] onehot_start(input int unsigned n);
    logic [MAX_LANES-1:0] v;
    v = '0;
    if (n != 0) v[0] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/frog_mover_if.sv
// rtl/frog_mover_if.sv - player-facing bus between game top and frog mover
// Signals:
//   go, back  raw pushbuttons, asynchronous to clk
//   respawn   synchronous level from the game top, 1 = frog hit a block
//   frog      one-hot frog position, bit0 = start, bit LANES-1 = goal
//   at_goal   high while the frog is held at the goal
//   moved     one-cycle pulse when a button moved the frog
// Modports: master = game top / stimulus side, slave = frog mover
interface frog_mover_if
  import frog_pkg::*;
#(
  parameter int LANES = LANES_DEF
);

  logic             go;
  logic             back;
  logic             respawn;
  logic [LANES-1:0] frog;
  logic             at_goal;
  logic             moved;

  modport master (
    output go, back, respawn,
    input  frog, at_goal, moved
  );

  modport slave (
    input  go, back, respawn,
    output frog, at_goal, moved
  );

endinterface

// File: rtl/frog_mover_btn_debounce.sv
// rtl/frog_mover_btn_debounce.sv - button synchronizer, debouncer and press detector
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   raw      raw button level, asynchronous to clk
//   level    debounced button level
//   rise_ev  one-cycle pulse after the debounced level goes 0->1
module btn_debounce
  import frog_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_ev
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q,  rise_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level   = level_q;
  assign rise_ev = rise_q;

endmodule

// File: rtl/frog_mover.sv
// rtl/frog_mover.sv - turns go/back buttons into a one-hot frog position
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  frog_mover_if.slave: go, back, respawn in; frog, at_goal, moved out
module frog_mover
  import frog_pkg::*;
#(
  parameter int LANES        = LANES_DEF,
  parameter int DEB_CYCLES   = 16,
  parameter int WIN_HOLD     = 4,
  parameter int RESPAWN_LOCK = 2
) (
  input  logic         clk,
  input  logic         rst,
  frog_mover_if.slave  bus
);

  localparam int HW = $clog2(WIN_HOLD + 1);
  localparam int LW = $clog2(RESPAWN_LOCK + 1);

  localparam logic [LANES-1:0] START_POS = LANES'(onehot_start(LANES));
  localparam logic [LANES-1:0] GOAL_POS  = {1'b1, {(LANES-1){1'b0}}};

  logic go_level, go_ev;
  logic back_level, back_ev;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_go_deb (
    .clk     (clk),
    .rst     (rst),
    .raw     (bus.go),
    .level   (go_level),
    .rise_ev (go_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_back_deb (
    .clk     (clk),
    .rst     (rst),
    .raw     (bus.back),
    .level   (back_level),
    .rise_ev (back_ev)
  );

  frog_state_t      state_q, state_d;
  logic [LANES-1:0] frog_q,  frog_d;
  logic [HW-1:0]    hold_q,  hold_d;
  logic [LW-1:0]    lock_q,  lock_d;
  logic             moved_q, moved_d;

  always_comb begin
    state_d = state_q;
    frog_d  = frog_q;
    hold_d  = hold_q;
    lock_d  = lock_q;
    moved_d = 1'b0;
    case (state_q)
      PLAY: begin
        if (bus.respawn) begin
          frog_d  = START_POS;
          lock_d  = LW'(RESPAWN_LOCK);
          state_d = LOCK;
        end else if (go_ev && back_ev) begin
          // Opposing presses in the same cycle cancel out.
        end else if (go_ev) begin
          frog_d  = frog_q << 1;
          moved_d = 1'b1;
          if (frog_q[LANES-2]) begin
            state_d = GOAL;
            hold_d  = HW'(WIN_HOLD);
          end
        end else if (back_ev) begin
          if (!frog_q[0]) begin
            frog_d  = frog_q >> 1;
            moved_d = 1'b1;
          end
        end
      end
      LOCK: begin
        frog_d = START_POS;
        if (bus.respawn) begin
          lock_d = LW'(RESPAWN_LOCK);
        end else if (lock_q <= LW'(1)) begin
          lock_d  = '0;
          state_d = PLAY;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end
      GOAL: begin
        frog_d = GOAL_POS;
        if (hold_q <= HW'(1)) begin
          hold_d  = '0;
          frog_d  = START_POS;
          state_d = PLAY;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: begin
        frog_d  = START_POS;
        state_d = PLAY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PLAY;
      frog_q  <= START_POS;
      hold_q  <= '0;
      lock_q  <= '0;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frog_q  <= frog_d;
      hold_q  <= hold_d;
      lock_q  <= lock_d;
      moved_q <= moved_d;
    end
  end

  assign bus.frog    = frog_q;
  assign bus.at_goal = (state_q == GOAL);
  assign bus.moved   = moved_q;

endmodule

// File: tb/tb_frog_mover.sv
// tb/tb_frog_mover.sv - self-checking bench for frog_mover
module tb_frog_mover;
  import frog_pkg::*;

  localparam int LANES = 19;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frog_mover_if #(.LANES(LANES)) bus ();

  frog_mover #(
    .LANES        (LANES),
    .DEB_CYCLES   (16),
    .WIN_HOLD     (4),
    .RESPAWN_LOCK (2)
  ) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb[$];
  int          pos;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every moved pulse must match the next expected position.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("onehot", 32'($onehot(bus.frog)), 32'd1);
      if (bus.moved) begin
        if (sb.size() == 0) begin
          check_eq("sb_spurious_moved", 32'(bus.moved), 32'd0);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          check_eq("sb_frog", 32'(bus.frog), e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic press(input bit use_go, input bit use_back);
    int np;
    np = pos;
    if (use_go && !use_back) np = pos + 1;
    else if (use_back && !use_go && pos > 0) np = pos - 1;
    if (np != pos) begin
      sb.push_back(32'd1 << np);
      pos = np;
    end
    bus.go   = use_go;
    bus.back = use_back;
    repeat (25) @(posedge clk);
    #1;
    bus.go   = 1'b0;
    bus.back = 1'b0;
    repeat (25) @(posedge clk);
    #1;
  endtask

  initial begin
    int mv;
    int ag;
    bus.go      = 1'b0;
    bus.back    = 1'b0;
    bus.respawn = 1'b0;
    pos         = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_frog", 32'(bus.frog), 32'h1);
    check_eq("rst_at_goal", 32'(bus.at_goal), 32'd0);
    check_eq("rst_moved", 32'(bus.moved), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Latency: go high from edge 0, frog moves on edge 19
    sb.push_back(32'h2);
    pos = 1;
    bus.go = 1'b1;
    mv = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.moved) mv++;
      if (k == 18) check_eq("lat_edge18_frog", 32'(bus.frog), 32'h1);
      if (k == 19) begin
        check_eq("lat_edge19_frog", 32'(bus.frog), 32'h2);
        check_eq("lat_edge19_moved", 32'(bus.moved), 32'd1);
      end
    end
    check_eq("lat_moved_cnt", 32'(mv), 32'd1);
    bus.go = 1'b0;
    repeat (25) @(posedge clk);
    #1;

    // Async reset in the middle of a debounce
    bus.go = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_frog", 32'(bus.frog), 32'h1);
    check_eq("midrst_at_goal", 32'(bus.at_goal), 32'd0);
    check_eq("midrst_moved", 32'(bus.moved), 32'd0);
    bus.go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos = 0;
    repeat (25) @(posedge clk);
    #1;
    check_eq("midrst_after_frog", 32'(bus.frog), 32'h1);

    // Bounce: toggling every 5 cycles never settles
    for (int k = 0; k < 100; k++) begin
      bus.go = ((k / 5) % 2) == 0;
      @(posedge clk);
      #1;
    end
    bus.go = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("bounce_frog", 32'(bus.frog), 32'h1);
    press(1'b1, 1'b0);
    check_eq("bounce_then_hold_frog", 32'(bus.frog), 32'h2);

    // Saturation at bit0 and simultaneous presses
    press(1'b0, 1'b1);
    check_eq("back_to_start", 32'(bus.frog), 32'h1);
    press(1'b0, 1'b1);
    check_eq("back_saturate", 32'(bus.frog), 32'h1);
    press(1'b1, 1'b1);
    check_eq("simul_frog", 32'(bus.frog), 32'h1);

    // Goal: 17 presses, then the winning press timed cycle by cycle
    for (int i = 0; i < 17; i++) press(1'b1, 1'b0);
    check_eq("pre_goal_frog", 32'(bus.frog), 32'h20000);
    sb.push_back(32'h40000);
    bus.go = 1'b1;
    ag = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.at_goal) ag++;
      if (k == 2) bus.back = 1'b1;
      if (k == 18) check_eq("goal_edge18_frog", 32'(bus.frog), 32'h20000);
      if (k == 19) begin
        check_eq("goal_edge19_frog", 32'(bus.frog), 32'h40000);
        check_eq("goal_edge19_at_goal", 32'(bus.at_goal), 32'd1);
        bus.respawn = 1'b1;
      end
      if (k == 20) bus.respawn = 1'b0;
      if (k == 21) begin
        check_eq("goal_hold_frog", 32'(bus.frog), 32'h40000);
        check_eq("goal_hold_moved", 32'(bus.moved), 32'd0);
        check_eq("goal_hold_at_goal", 32'(bus.at_goal), 32'd1);
      end
      if (k == 23) begin
        check_eq("goal_exit_frog", 32'(bus.frog), 32'h1);
        check_eq("goal_exit_at_goal", 32'(bus.at_goal), 32'd0);
      end
    end
    check_eq("goal_hold_cycles", 32'(ag), 32'd4);
    bus.go   = 1'b0;
    bus.back = 1'b0;
    pos = 0;
    repeat (25) @(posedge clk);
    #1;
    check_eq("goal_after_frog", 32'(bus.frog), 32'h1);

    // Respawn at bit5, go event inside the lock window is dropped
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    check_eq("pre_respawn_frog", 32'(bus.frog), 32'h20);
    bus.go = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 17) bus.respawn = 1'b1;
      if (k == 18) begin
        check_eq("respawn_frog", 32'(bus.frog), 32'h1);
        bus.respawn = 1'b0;
      end
      if (k == 19) begin
        check_eq("lock_drop_frog", 32'(bus.frog), 32'h1);
        check_eq("lock_drop_moved", 32'(bus.moved), 32'd0);
      end
      if (k == 21) check_eq("lock_exit_frog", 32'(bus.frog), 32'h1);
    end
    bus.go = 1'b0;
    pos = 0;
    repeat (25) @(posedge clk);
    #1;
    check_eq("respawn_idle_frog", 32'(bus.frog), 32'h1);
    press(1'b1, 1'b0);
    check_eq("respawn_then_go_frog", 32'(bus.frog), 32'h2);

    repeat (5) @(posedge clk);
    #1;
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
